// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Also holds the small combinational helpers used by the top-level FSM.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      CAND    = 2'd1,
      PRESSED = 2'd2,
      REL     = 2'd3
   } state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Row drive is a one-hot-low vector; recover the row number for the key code.
   function automatic logic [1:0] row_index(input logic [3:0] row_n);
      logic [1:0] idx;
      case (row_n)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] col_pick(input logic [3:0] col_n);
      logic [1:0] idx;
      if (!col_n[0])      idx = 2'd0;
      else if (!col_n[1]) idx = 2'd1;
      else if (!col_n[2]) idx = 2'd2;
      else                idx = 2'd3;
      return idx;
   endfunction

   // cur is at most 99, so (cur mod 10)*10 + digit never exceeds 99.
   function automatic logic [7:0] entry_shift(input logic [7:0] cur, input logic [3:0] digit);
      logic [7:0] low;
      low = cur % 8'd10;
      return (low * 8'd10) + {4'd0, digit};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Resets to all-ones so that idle pulled-up lines read as released.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, tick-based debounce, one key_valid
// pulse per accepted press and a rolling two-digit decimal entry register.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_W   = 16,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [7:0] entry_val
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

   logic [SCAN_DIV_W-1:0] div_q;
   logic                  tick;
   logic [3:0]            col_s;
   logic                  hit;
   logic [3:0]            code;

   state_e     state_q;
   logic [3:0] row_q;
   logic [3:0] cand_q;
   logic [3:0] cnt_q;
   logic [3:0] cnt_inc;
   logic [3:0] row_rot;
   logic [3:0] key_code_q;
   logic       key_valid_q;
   logic       key_held_q;
   logic [7:0] entry_q;
   logic [7:0] entry_d;

   sync_2ff #(.W(4)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d_i (col_in),
      .q_o (col_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= div_q + SCAN_DIV_W'(1);
   end

   assign tick    = &div_q;
   assign hit     = ~&col_s;
   assign code    = {row_index(row_q), col_pick(col_s)};
   assign cnt_inc = cnt_q + 4'd1;
   assign row_rot = {row_q[2:0], row_q[3]};

   always_comb begin
      entry_d = entry_q;
      if (cand_q <= 4'd9)
         entry_d = entry_shift(entry_q, cand_q);
      else if (cand_q == KEY_CLEAR)
         entry_d = 8'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SCAN;
         row_q       <= ROW_RESET;
         cand_q      <= 4'd0;
         cnt_q       <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         entry_q     <= 8'd0;
      end else begin
         key_valid_q <= 1'b0;
         if (tick) begin
            case (state_q)
               SCAN: begin
                  if (hit) begin
                     cand_q  <= code;
                     cnt_q   <= 4'd1;
                     state_q <= CAND;
                  end else begin
                     row_q <= row_rot;
                  end
               end
               CAND: begin
                  if (hit && (code == cand_q)) begin
                     if (cnt_inc == DEB) begin
                        state_q     <= PRESSED;
                        key_code_q  <= cand_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        entry_q     <= entry_d;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
                  end else begin
                     state_q <= SCAN;
                     row_q   <= row_rot;
                  end
               end
               PRESSED: begin
                  if (!hit) begin
                     cnt_q   <= 4'd1;
                     state_q <= REL;
                  end
               end
               REL: begin
                  // A key reappearing mid-release is the same press bouncing, not a new one.
                  if (hit) begin
                     state_q <= PRESSED;
                  end else if (cnt_inc == DEB) begin
                     key_held_q <= 1'b0;
                     state_q    <= SCAN;
                     row_q      <= row_rot;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign row_out   = row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign entry_val = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner with a tick-level keypad model.
// The bench emulates the keypad matrix from row_out and the set of held keys.
module tb_keypad_scanner;

   localparam int DIV_W     = 2;
   localparam int DEB       = 4;
   localparam int TICK_CLKS = 1 << DIV_W;

   logic       clk;
   logic       rst;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [7:0] entry_val;

   keypad_scanner #(.SCAN_DIV_W(DIV_W), .DEBOUNCE_CNT(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .entry_val (entry_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int dut_pulses = 0;

   logic [15:0] keys;     // bit r*4+c set = key at row r, column c held down
   bit          pulse_pending;

   // Reference model state: scanned row, whether a press is held, streak counters.
   int       m_row;
   bit       m_held;
   int       m_streak;
   int       m_quiet;
   int       m_cand;
   int       m_code;
   int       m_entry;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_row = 0; m_held = 0; m_streak = 0; m_quiet = 0;
      m_cand = 0; m_code = 0; m_entry = 0;
      pulse_pending = 0;
   endtask

   task automatic drive_cols();
      logic [3:0] c_n;
      c_n = 4'hF;
      for (int r = 0; r < 4; r++)
         if (row_out[r] == 1'b0)
            for (int c = 0; c < 4; c++)
               if (keys[r*4+c]) c_n[c] = 1'b0;
      col_in = c_n;
   endtask

   task automatic model_tick(output bit acc);
      bit h;
      int code;
      acc = 0; h = 0; code = 0;
      for (int c = 3; c >= 0; c--)
         if (keys[m_row*4+c]) begin
            h = 1;
            code = m_row*4 + c;
         end
      if (m_held) begin
         if (h) m_quiet = 0;
         else begin
            m_quiet++;
            if (m_quiet == DEB) begin
               m_held = 0; m_quiet = 0; m_row = (m_row + 1) % 4;
            end
         end
      end else if (m_streak == 0) begin
         if (h) begin m_cand = code; m_streak = 1; end
         else m_row = (m_row + 1) % 4;
      end else if (h && code == m_cand) begin
         m_streak++;
         if (m_streak == DEB) begin
            acc = 1; m_held = 1; m_streak = 0; m_quiet = 0; m_code = m_cand;
            if (m_cand <= 9) m_entry = (m_entry % 10) * 10 + m_cand;
            else if (m_cand == 12) m_entry = 0;
         end
      end else begin
         m_streak = 0; m_row = (m_row + 1) % 4;
      end
   endtask

   task automatic check_reset_outputs();
      check_val("rst_row", row_out, 4'b1110);
      check_val("rst_valid", key_valid, 0);
      check_val("rst_held", key_held, 0);
      check_val("rst_entry", entry_val, 0);
      check_val("rst_code", key_code, 0);
   endtask

   // Runs n scan ticks from a negedge just after a tick edge (or reset release).
   task automatic run_ticks(input int n);
      bit acc;
      logic [3:0] er;
      for (int t = 0; t < n; t++) begin
         drive_cols();
         for (int k = 1; k <= TICK_CLKS; k++) begin
            @(negedge clk);
            if (k == 1 && pulse_pending) begin
               check_val("valid_width", key_valid, 0);
               pulse_pending = 0;
            end
         end
         model_tick(acc);
         if (acc) begin
            pulse_pending = 1;
            $display("%0t accept key=%0d entry=%0d", $time, m_code, m_entry);
         end
         if (key_valid) dut_pulses++;
         er = 4'hF;
         er[m_row] = 1'b0;
         check_val("row_out", row_out, er);
         check_val("key_valid", key_valid, acc);
         check_val("key_held", key_held, m_held);
         check_val("key_code", key_code, m_code);
         check_val("entry_val", entry_val, m_entry);
      end
   endtask

   task automatic align_row(input int r);
      for (int i = 0; i < 4 && m_row != r; i++) run_ticks(1);
   endtask

   task automatic tap(input int k, input int hold, input int gap);
      keys = 16'h0;
      keys[k] = 1'b1;
      run_ticks(hold);
      keys = 16'h0;
      run_ticks(gap);
   endtask

   initial begin
      int p0;
      rst = 1'b0; col_in = 4'hF; keys = 16'h0;
      model_reset();
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      @(negedge clk) rst = 1'b0;
      run_ticks(6);

      // Clean press of key 6, then check the release debounce boundary.
      p0 = dut_pulses;
      keys = 16'h0; keys[6] = 1'b1;
      run_ticks(20);
      check_val("clean_code", key_code, 6);
      check_val("clean_entry", entry_val, 6);
      keys = 16'h0;
      run_ticks(3);
      check_val("held_3_empty", key_held, 1);
      run_ticks(1);
      check_val("held_4_empty", key_held, 0);
      check_val("clean_pulses", dut_pulses - p0, 1);
      run_ticks(4);

      // Short bounce on row 0 must never be accepted.
      align_row(0);
      p0 = dut_pulses;
      keys = 16'h0; keys[1] = 1'b1;
      run_ticks(2);
      keys = 16'h0;
      run_ticks(8);
      check_val("bounce_pulses", dut_pulses - p0, 0);

      // Clear, then digits 4, 7, 5, then clear again.
      tap(12, 10, 8);
      check_val("clear_first", entry_val, 0);
      tap(4, 10, 8);
      check_val("entry_4", entry_val, 4);
      tap(7, 10, 8);
      check_val("entry_47", entry_val, 47);
      tap(5, 10, 8);
      check_val("entry_75", entry_val, 75);
      tap(12, 10, 8);
      check_val("entry_clr", entry_val, 0);

      // Two columns on row 2, plus a release bounce that must not re-trigger.
      p0 = dut_pulses;
      keys = 16'h0; keys[9] = 1'b1; keys[11] = 1'b1;
      run_ticks(12);
      check_val("twocol_code", key_code, 9);
      keys = 16'h0;
      run_ticks(2);
      keys[9] = 1'b1; keys[11] = 1'b1;
      run_ticks(6);
      keys = 16'h0;
      run_ticks(8);
      check_val("twocol_pulses", dut_pulses - p0, 1);

      // Asynchronous reset while a key is held; the key is then re-accepted.
      keys = 16'h0; keys[5] = 1'b1;
      run_ticks(12);
      check_val("pre_rst_held", key_held, 1);
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      @(negedge clk) rst = 1'b0;
      model_reset();
      p0 = dut_pulses;
      run_ticks(12);
      check_val("rst_repress_pulses", dut_pulses - p0, 1);
      check_val("rst_repress_entry", entry_val, 5);
      keys = 16'h0;
      run_ticks(8);

      // Random episodes of one or two keys with random hold and gap lengths.
      for (int e = 0; e < 50; e++) begin
         keys = 16'h0;
         keys[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
         run_ticks($urandom_range(1, 12));
         keys = 16'h0;
         run_ticks($urandom_range(0, 8));
      end
      run_ticks(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
